// File: rtl/int_controller.sv
// Interrupt controller: synchronises async sources, latches rising edges as pending,
// masks and prioritises them, and holds a level request to the CPU until it is serviced.
module int_controller #(
    parameter int unsigned NUM_SRC  = 4,
    parameter int unsigned CAUSE_W  = 3,
    parameter int unsigned MASK_RST = 0
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NUM_SRC-1:0] src_i,
    input  logic               in_handler_i,
    input  logic               we_i,
    input  logic [1:0]         addr_i,
    input  logic [31:0]        wdata_i,
    output logic [31:0]        rdata_o,
    output logic               int_o,
    output logic [CAUSE_W-1:0] cause_o,
    output logic               int_active_o
);

    localparam logic [1:0] ADDR_PEND = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd1;
    localparam logic [1:0] ADDR_STAT = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERVICE, S_GAP} state_t;

    state_t               state_q, state_d;
    logic [NUM_SRC-1:0]   s1_q, s2_q, s3_q;
    logic [NUM_SRC-1:0]   pending_q, pending_d;
    logic [NUM_SRC-1:0]   mask_q, mask_d;
    logic                 int_q, int_d;
    logic                 active_q, active_d;
    logic [CAUSE_W-1:0]   cause_q, cause_d;

    logic [NUM_SRC-1:0]   rise_c, w1c_c, svc_clr_c, pm_c, cause_oh_c, pend_live_c;
    logic [CAUSE_W-1:0]   sel_c;
    logic                 req_c, sel_found_c, unused_wdata_c;

    assign unused_wdata_c = ^wdata_i;

    assign rise_c      = s2_q & ~s3_q;
    assign w1c_c       = (we_i && addr_i == ADDR_PEND) ? wdata_i[NUM_SRC-1:0] : '0;
    assign mask_d      = (we_i && addr_i == ADDR_MASK) ? wdata_i[NUM_SRC-1:0] : mask_q;
    assign pm_c        = pending_q & mask_q;
    assign req_c       = |pm_c;
    assign cause_oh_c  = NUM_SRC'(1) << cause_q;
    // Pending view after this cycle's SW clear, used to withdraw a request promptly
    assign pend_live_c = (pending_q & ~w1c_c) | rise_c;
    // A new edge on the same bit outranks any clear in the same cycle
    assign pending_d   = (pending_q & ~(w1c_c | svc_clr_c)) | rise_c;

    // Fixed priority: lowest enabled pending index wins
    always_comb begin
        sel_c       = '0;
        sel_found_c = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (pm_c[i] && !sel_found_c) begin
                sel_c       = CAUSE_W'(i);
                sel_found_c = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        int_d     = int_q;
        cause_d   = cause_q;
        active_d  = active_q;
        svc_clr_c = '0;
        case (state_q)
            S_IDLE: begin
                if (req_c) begin
                    state_d = S_REQ;
                    cause_d = sel_c;
                    int_d   = 1'b1;
                end
            end
            S_REQ: begin
                if (!(|(pend_live_c & mask_d & cause_oh_c))) begin
                    state_d = S_IDLE;
                    int_d   = 1'b0;
                end else if (in_handler_i) begin
                    state_d   = S_SERVICE;
                    int_d     = 1'b0;
                    active_d  = 1'b1;
                    svc_clr_c = cause_oh_c;
                end
            end
            S_SERVICE: begin
                if (!in_handler_i) begin
                    state_d  = S_GAP;
                    active_d = 1'b0;
                end
            end
            S_GAP: begin
                state_d = S_IDLE;
                int_d   = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_q      <= '0;
            s2_q      <= '0;
            s3_q      <= '0;
            pending_q <= '0;
            mask_q    <= NUM_SRC'(MASK_RST);
            state_q   <= S_IDLE;
            int_q     <= 1'b0;
            cause_q   <= '0;
            active_q  <= 1'b0;
        end else begin
            s1_q      <= src_i;
            s2_q      <= s1_q;
            s3_q      <= s2_q;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            state_q   <= state_d;
            int_q     <= int_d;
            cause_q   <= cause_d;
            active_q  <= active_d;
        end
    end

    assign int_o        = int_q;
    assign cause_o      = cause_q;
    assign int_active_o = active_q;

    // Register read mux; unused bits read as zero
    always_comb begin
        rdata_o = '0;
        case (addr_i)
            ADDR_PEND: rdata_o[NUM_SRC-1:0] = pending_q;
            ADDR_MASK: rdata_o[NUM_SRC-1:0] = mask_q;
            ADDR_STAT: begin
                rdata_o[9]           = active_q;
                rdata_o[8]           = int_q;
                rdata_o[CAUSE_W-1:0] = cause_q;
            end
            default: rdata_o = '0;
        endcase
    end

endmodule

// File: tb/tb_int_controller.sv
// Directed bench for int_controller: register-access vector table plus
// hand-written sequences for edge capture, priority, withdrawal and reset.
module tb_int_controller;

    localparam int unsigned NUM_SRC = 4;
    localparam int unsigned CAUSE_W = 3;

    logic               clk = 1'b0;
    logic               rstn;
    logic [NUM_SRC-1:0] src_i;
    logic               in_handler_i;
    logic               we_i;
    logic [1:0]         addr_i;
    logic [31:0]        wdata_i;
    logic [31:0]        rdata_o;
    logic               int_o;
    logic [CAUSE_W-1:0] cause_o;
    logic               int_active_o;

    int n_checks = 0;
    int n_fail   = 0;

    int_controller #(.NUM_SRC(NUM_SRC), .CAUSE_W(CAUSE_W), .MASK_RST(0)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .src_i        (src_i),
        .in_handler_i (in_handler_i),
        .we_i         (we_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .rdata_o      (rdata_o),
        .int_o        (int_o),
        .cause_o      (cause_o),
        .int_active_o (int_active_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        we_i    = 1'b1;
        addr_i  = a;
        wdata_i = d;
        tick();
        we_i    = 1'b0;
        wdata_i = '0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        addr_i = a;
        #1;
        d = rdata_o;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    logic [31:0] rv;

    initial begin
        vecs[0] = '{we: 1'b1, addr: 2'd1, wdata: 32'h0000_00A5, exp_rd: 32'h5};
        vecs[1] = '{we: 1'b0, addr: 2'd3, wdata: 32'h0,         exp_rd: 32'h0};
        vecs[2] = '{we: 1'b1, addr: 2'd3, wdata: 32'hFFFF_FFFF, exp_rd: 32'h0};
        vecs[3] = '{we: 1'b1, addr: 2'd2, wdata: 32'h0000_0FFF, exp_rd: 32'h0};
        vecs[4] = '{we: 1'b0, addr: 2'd1, wdata: 32'h0,         exp_rd: 32'h5};
        vecs[5] = '{we: 1'b1, addr: 2'd0, wdata: 32'h0000_000F, exp_rd: 32'h0};
        vecs[6] = '{we: 1'b1, addr: 2'd1, wdata: 32'h0,         exp_rd: 32'h0};

        rstn = 1'b0; src_i = '0; in_handler_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
        ticks(2);
        check("rst_int", 32'(int_o), 32'h0);
        check("rst_cause", 32'(cause_o), 32'h0);
        check("rst_active", 32'(int_active_o), 32'h0);
        rd(2'd0, rv); check("rst_pend", rv, 32'h0);
        rd(2'd1, rv); check("rst_mask", rv, 32'h0);
        rstn = 1'b1;
        tick();

        // Register access table
        for (int v = 0; v < 7; v++) begin
            if (vecs[v].we) wr(vecs[v].addr, vecs[v].wdata);
            rd(vecs[v].addr, rv);
            check($sformatf("vec%0d_rd", v), rv, vecs[v].exp_rd);
        end

        // T1: single source, full handshake
        wr(2'd1, 32'hF);
        src_i = 4'b0010;
        ticks(2);
        rd(2'd0, rv); check("t1_pend_e1", rv, 32'h0);
        tick();
        rd(2'd0, rv); check("t1_pend_e2", rv, 32'h2);
        check("t1_int_e2", 32'(int_o), 32'h0);
        tick();
        check("t1_int_e3", 32'(int_o), 32'h1);
        check("t1_cause", 32'(cause_o), 32'h1);
        in_handler_i = 1'b1;
        tick();
        check("t1_int_svc", 32'(int_o), 32'h0);
        check("t1_active", 32'(int_active_o), 32'h1);
        rd(2'd0, rv); check("t1_pend_svc", rv, 32'h0);
        in_handler_i = 1'b0;
        tick();
        check("t1_active_gap", 32'(int_active_o), 32'h0);
        check("t1_int_gap", 32'(int_o), 32'h0);
        tick();
        rd(2'd2, rv); check("t1_stat_idle", rv, 32'h1);
        src_i = '0;
        ticks(3);

        // T2: simultaneous edges, priority then automatic second request
        src_i = 4'b1001;
        ticks(4);
        check("t2_int1", 32'(int_o), 32'h1);
        check("t2_cause1", 32'(cause_o), 32'h0);
        in_handler_i = 1'b1;
        tick();
        rd(2'd0, rv); check("t2_pend_svc", rv, 32'h8);
        in_handler_i = 1'b0;
        tick();
        tick();
        check("t2_int_idle", 32'(int_o), 32'h0);
        tick();
        check("t2_int2", 32'(int_o), 32'h1);
        check("t2_cause2", 32'(cause_o), 32'h3);
        in_handler_i = 1'b1; tick();
        in_handler_i = 1'b0; ticks(2);
        src_i = '0;
        ticks(3);

        // T3: masked pending, then unmask
        wr(2'd1, 32'h0);
        src_i = 4'b0100;
        ticks(3);
        rd(2'd0, rv); check("t3_pend", rv, 32'h4);
        tick();
        check("t3_int_masked", 32'(int_o), 32'h0);
        wr(2'd1, 32'h4);
        check("t3_int_wr_edge", 32'(int_o), 32'h0);
        tick();
        check("t3_int", 32'(int_o), 32'h1);
        rd(2'd2, rv); check("t3_stat", rv, 32'h102);
        in_handler_i = 1'b1; tick();
        in_handler_i = 1'b0; ticks(2);
        src_i = '0;
        ticks(3);

        // T4: SW clear withdraws request; stray ack ignored
        wr(2'd1, 32'hF);
        src_i = 4'b0010;
        ticks(4);
        check("t4_int", 32'(int_o), 32'h1);
        check("t4_cause", 32'(cause_o), 32'h1);
        wr(2'd0, 32'h2);
        check("t4_int_withdrawn", 32'(int_o), 32'h0);
        rd(2'd0, rv); check("t4_pend", rv, 32'h0);
        in_handler_i = 1'b1; ticks(2);
        check("t4_stray_int", 32'(int_o), 32'h0);
        check("t4_stray_active", 32'(int_active_o), 32'h0);
        in_handler_i = 1'b0;
        src_i = '0;
        ticks(3);

        // T5: W1C coincident with edge on the same bit
        src_i = 4'b0001;
        ticks(2);
        wr(2'd0, 32'h1);
        rd(2'd0, rv); check("t5_set_wins", rv, 32'h1);
        tick();
        check("t5_int", 32'(int_o), 32'h1);
        check("t5_cause", 32'(cause_o), 32'h0);
        in_handler_i = 1'b1;
        tick();
        check("t5_active", 32'(int_active_o), 32'h1);

        // T6: async reset during SERVICE, source held high
        #2 rstn = 1'b0;
        #1;
        check("t6_int", 32'(int_o), 32'h0);
        check("t6_active", 32'(int_active_o), 32'h0);
        check("t6_cause", 32'(cause_o), 32'h0);
        rd(2'd0, rv); check("t6_pend", rv, 32'h0);
        rd(2'd1, rv); check("t6_mask", rv, 32'h0);
        in_handler_i = 1'b0;
        tick();
        rstn = 1'b1;
        ticks(3);
        rd(2'd0, rv); check("t6_one_edge", rv, 32'h1);
        wr(2'd0, 32'h1);
        ticks(4);
        rd(2'd0, rv); check("t6_no_second_edge", rv, 32'h0);
        check("t6_int_masked", 32'(int_o), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
